// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffer entry payload
// and sizing helpers.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Bits needed to hold an occupancy count of 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Shift-style instruction FIFO: the head always lives in slot 0 so decode sees
// flopped data. Flush beats push; push into a full buffer is allowed only with a pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic             pop_en;
  logic             push_en;
  logic [CNT_W-1:0] wr_idx;

  // Valid bits are contiguous from slot 0, so occupancy is their population count.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(vld_q[i]);
    end
  end

  assign empty   = !vld_q[0];
  assign full    = vld_q[DEPTH-1];
  assign head    = mem_q[0];
  assign pop_en  = pop && vld_q[0];
  assign push_en = push && (!full || pop_en);
  assign wr_idx  = count - CNT_W'(pop_en);

  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    if (pop_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      vld_d[DEPTH-1] = 1'b0;
    end
    if (push_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CNT_W'(i)) begin
          mem_d[i] = push_data;
          vld_d[i] = 1'b1;
        end
      end
    end
    if (flush) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests,
// buffers returned words and handles redirects. FETCH_MISALIGN_CHECK_EN enables
// the misaligned-target halt; without it target bits [1:0] are forced to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(0),
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] ins,
  output logic [WIDTH-1:0] ins_pc,
  output logic             ins_valid,
  input  logic             ins_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             misalign
);

  localparam int unsigned CNT_W = cnt_width(BUF_DEPTH);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [WIDTH-1:0] fetch_pc_q;
  logic [WIDTH-1:0] fetch_pc_d;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] addr_d;
  logic             req_q;
  logic             req_d;

  logic             acc;
  logic             pop;
  logic             push;
  logic             flush;
  logic             halt_c;
  logic [WIDTH-1:0] target;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             buf_full;
  logic             buf_empty;
  fetch_entry_t     head;
  fetch_entry_t     push_data;

  assign acc       = req_q && imem_ack;
  assign pop       = !buf_empty && ins_ready;
  assign target    = redirect_target & ~WIDTH'(3);
  assign push_data = '{ins: XLEN'(imem_rdata), pc: XLEN'(fetch_pc_q)};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_d;

  // Sticky until reset; also tells DRAIN whether to land in HALT.
  assign misalign_d = misalign_q | (redirect && (redirect_target[1:0] != 2'b00));
  assign halt_c     = misalign_d;
  assign misalign   = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign halt_c   = 1'b0;
  assign misalign = 1'b0;
`endif

  // Next state, PC and buffer controls; issue decision uses next-cycle occupancy.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;

    case (state_q)
      FETCH, FULL: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target;
          if (req_q && !imem_ack) begin
            state_d = DRAIN;
          end else if (halt_c) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
          end
        end else if (acc) begin
          push       = !buf_full || pop;
          fetch_pc_d = fetch_pc_q + WIDTH'(INSTR_BYTES);
        end
      end
      DRAIN: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target;
        end
        if (acc) begin
          state_d = halt_c ? HALT : FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    count_d = flush ? '0 : (count + CNT_W'(push) - CNT_W'(pop));

    if (state_d == FETCH || state_d == FULL) begin
      state_d = (count_d == CNT_W'(BUF_DEPTH)) ? FULL : FETCH;
    end

    // DRAIN keeps the stale request on the bus until it is acknowledged.
    req_d  = (state_d == FETCH) || (state_d == DRAIN);
    addr_d = (state_d == DRAIN) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ins       = WIDTH'(head.ins);
  assign ins_pc    = WIDTH'(head.pc);
  assign ins_valid = !buf_empty;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `control_unit`. Owns the program counter and issues single-outstanding requests to instruction memory. Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake. Takes the decoded branch decision (`pc_src`) and target back from decode/execute as a redirect, which flushes in-flight and buffered work.

## Interface
- `WIDTH`, 32: instruction and address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, 2: instruction buffer entries; legal values are 2 or 4.

- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out WIDTH: fetch byte address, always 4-aligned.
- `imem_ack` in 1: memory accepts the request and returns data in the same cycle.
- `imem_rdata` in WIDTH: instruction word, valid when `imem_ack` is high.
- `ins` out WIDTH: instruction to decode.
- `ins_pc` out WIDTH: PC of `ins`.
- `ins_valid` out 1: buffer head is valid.
- `ins_ready` in 1: decode consumes the head this cycle.
- `redirect` in 1: one-cycle branch-taken pulse (`pc_src`).
- `redirect_target` in WIDTH: new fetch address, sampled when `redirect` is high.
- `misalign` out 1: sticky misaligned-target flag. Driven only under `FETCH_MISALIGN_CHECK_EN`; tied 0 otherwise.

## Operation
- FSM states:
  - FETCH: may issue a request.
  - FULL: buffer full, no request.
  - DRAIN: waiting to discard a stale response.
  - HALT: only under `FETCH_MISALIGN_CHECK_EN`.
- Issue rule: `imem_req` is high in FETCH when buffer count < `BUF_DEPTH`. At most one request is outstanding.
- Request hold: `imem_addr`/`imem_req` stay stable until `imem_ack`.
- On `imem_ack` (not draining):
  - push {`imem_rdata`, `fetch_pc`} into the buffer;
  - `fetch_pc` <= `fetch_pc` + 4, wrapping modulo 2^WIDTH.
- Pop: `ins_valid && ins_ready` removes the head. Push and pop in the same cycle are both performed. A full buffer plus a pop re-enables issue on the next cycle.
- Redirect:
  - flush the buffer (count <= 0);
  - `fetch_pc` <= `redirect_target`;
  - if a request is pending and not acked this cycle, go to DRAIN. DRAIN holds the old address until ack, discards that data, then returns to FETCH.
- Redirect and `imem_ack` in the same cycle: the acked word is discarded and no DRAIN is entered.
- Redirect and pop in the same cycle: the flush wins, and `ins_valid` = 0 on the next cycle.
- Redirect while in FULL: flush, go to FETCH.

## Timing
- Reset values:
  - `imem_req` = 0;
  - `imem_addr` = `RESET_PC`;
  - `ins` = 0, `ins_pc` = 0, `ins_valid` = 0;
  - `misalign` = 0;
  - state = FETCH, count = 0.
- First cycle after `rst` falls: `imem_req` = 1, `imem_addr` = `RESET_PC`.
- Latency: ack in cycle N gives `ins_valid` in cycle N+1.
- Throughput: one instruction per cycle when ack is immediate and decode is always ready.
- Redirect in cycle N:
  - `imem_addr` = target in N+1 (no drain), or one cycle after the stale ack (drain);
  - first target instruction is valid the cycle after its ack.
- `ins`/`ins_pc` hold their value while `ins_valid && !ins_ready`.
- Reset mid-request: the outstanding request is abandoned with no drain, and any late ack is ignored.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - a redirect with `redirect_target[1:0] != 0` sets `misalign` (sticky until `rst`);
  - flushes the buffer and enters HALT;
  - in HALT, no further requests and `ins_valid` = 0;
  - a stale outstanding request is still drained before HALT.
- Undefined: `redirect_target[1:0]` is forced to 2'b00 and `misalign` is constant 0.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum (FETCH, FULL, DRAIN, HALT);
  - `INSTR_BYTES` = 4;
  - `fetch_entry_t` struct {ins, pc}.
- Sub-module `fetch_buffer`:
  - synchronous FIFO of `fetch_entry_t`, depth `BUF_DEPTH`, with push/pop/flush;
  - outputs count, full, empty;
  - flush has priority over push.
- `fetch_unit` holds the PC, FSM and redirect/drain logic.

## Test plan
- Reset release, immediate ack, `ins_ready` = 1: addresses 0x0, 0x4, 0x8. `ins_pc` follows one cycle behind. Memory word 0x00500093 (addi) appears as `ins` with `ins_pc` = 0x0.
- `ins_ready` = 0 for 5 cycles with `BUF_DEPTH` = 2: two entries buffered, then `imem_req` = 0. Re-assert ready: entries pop in order 0x0, 0x4, and fetch resumes at 0x8.
- Ack delayed 3 cycles, redirect to 0x40 in cycle 1 of the wait: 0x8 stays on `imem_addr` until ack, its data is dropped, the next request is 0x40, and no `ins_pc` = 0x8 ever appears.
- Redirect to 0x100 coincident with ack and pop: the buffer is empty next cycle, `imem_addr` = 0x100, and the first valid `ins_pc` = 0x100.
- PC wrap: redirect to 0xFFFF_FFFC; the following fetch is 0x0000_0000.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x42 gives `misalign` = 1, no further `imem_req`, and `ins_valid` = 0 until `rst`. Without the macro, fetch goes to 0x40.
